// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: ALU select codes, sequencer states and status-bit layout shared by the UART/ALU glue.
package alu_uart_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam int STAT_ZERO = 0;
    localparam int STAT_ILL  = 1;
    typedef enum logic [2:0] {
        S_IDLE, S_GET_B, S_GET_OP, S_EXEC, S_SEND_RES, S_WAIT_RES, S_SEND_STAT, S_WAIT_STAT
    } state_e;
    function automatic logic is_illegal(input logic [3:0] sel);
        return !(sel inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT});
    endfunction
endpackage

// File: rtl/alu_uart_timeout.sv
// alu_uart_timeout: inter-byte cycle counter; pulses expired when TIMEOUT cycles pass without clr.
module alu_uart_timeout #(
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_W    = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TO_W-1:0] cnt_q, cnt_d;
    always_comb begin
        expired = en && !clr && (cnt_q == TO_W'(TIMEOUT - 1));
        cnt_d   = (clr || expired || !en) ? '0 : cnt_q + TO_W'(1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/alu_uart_interface.sv
// alu_uart_interface: collects A, B, op bytes from the UART, runs the external ALU,
// and returns a result byte followed by a status byte.
module alu_uart_interface
    import alu_uart_pkg::*;
#(
    parameter int BITS    = 8,
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_W    = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      rx_data,
    input  logic            rx_done,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_done,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    output logic [3:0]      alu_sel,
    input  logic [BITS-1:0] alu_c,
    input  logic            alu_zero,
    output logic            busy,
    output logic            frame_err
);
    state_e          state_q, state_d;
    logic [BITS-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]      sel_q, sel_d;
    logic [7:0]      stat_q, stat_d, tx_data_q, tx_data_d;
    logic            frame_err_q, frame_err_d;
    logic            expired;

    alu_uart_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (rx_done),
        .en      (state_q == S_GET_B || state_q == S_GET_OP),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        res_d       = res_q;
        stat_d      = stat_q;
        tx_data_d   = tx_data_q;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: if (rx_done) begin
                a_d     = rx_data;
                state_d = S_GET_B;
            end
            S_GET_B: if (rx_done) begin
                b_d     = rx_data;
                state_d = S_GET_OP;
            end else if (expired) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_GET_OP: if (rx_done) begin
                sel_d   = rx_data[3:0];
                state_d = S_EXEC;
            end else if (expired) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_EXEC: begin
                // tx_data is loaded alongside res_q so it is valid in the same cycle as tx_start
                res_d             = alu_c;
                tx_data_d         = alu_c;
                stat_d            = '0;
                stat_d[STAT_ZERO] = alu_zero;
                stat_d[STAT_ILL]  = is_illegal(sel_q);
                state_d           = S_SEND_RES;
            end
            S_SEND_RES: state_d = S_WAIT_RES;
            S_WAIT_RES: if (tx_done) begin
                tx_data_d = stat_q;
                state_d   = S_SEND_STAT;
            end
            S_SEND_STAT: state_d = S_WAIT_STAT;
            S_WAIT_STAT: if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            res_q       <= '0;
            stat_q      <= '0;
            tx_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            res_q       <= res_d;
            stat_q      <= stat_d;
            tx_data_q   <= tx_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign tx_data   = tx_data_q;
    assign frame_err = frame_err_q;
    assign tx_start  = (state_q == S_SEND_RES) || (state_q == S_SEND_STAT);
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_uart_interface.sv
// tb_alu_uart_interface: directed frames through a behavioural ALU, plus timeout and reset corner cases.
module tb_alu_uart_interface;
    import alu_uart_pkg::*;
    localparam int T = 20;

    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] rx_data = '0, tx_data, alu_a, alu_b, alu_c;
    logic       rx_done = 1'b0, tx_done = 1'b0, tx_start, alu_zero, busy, frame_err;
    logic [3:0] alu_sel;
    int         checks = 0, errors = 0, fe_cnt = 0, ts_cnt = 0;

    typedef struct {
        logic [7:0] a, b, op, res, stat;
    } vec_t;
    vec_t v[7];

    alu_uart_interface #(.BITS(8), .TIMEOUT(T), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
        .alu_zero(alu_zero), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_c = 8'hFF;
        if (alu_sel == ALU_ADD) alu_c = alu_a + alu_b;
        if (alu_sel == ALU_SUB) alu_c = alu_a - alu_b;
        if (alu_sel == ALU_AND) alu_c = alu_a & alu_b;
        if (alu_sel == ALU_OR)  alu_c = alu_a | alu_b;
        if (alu_sel == ALU_SLT) alu_c = ($signed(alu_a) < $signed(alu_b)) ? 8'd1 : 8'd0;
        alu_zero = (alu_sel == ALU_SUB) && (alu_c == 8'd0);
    end

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (tx_start) ts_cnt++;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic run_frame(input int i, input int gap, input bit inject);
        int fe0, ts0;
        fe0 = fe_cnt;
        ts0 = ts_cnt;
        send(v[i].a);
        repeat (gap) tick();
        send(v[i].b);
        tick();
        send(v[i].op);
        chk("exec_no_start", 32'(tx_start), 0);
        tick();
        chk("res_start", 32'(tx_start), 1);
        chk("res_byte", 32'(tx_data), 32'(v[i].res));
        chk("sel", 32'(alu_sel), 32'(v[i].op[3:0]));
        tick();
        chk("res_pulse", 32'(tx_start), 0);
        if (inject) send(8'h55);
        else tick();
        repeat (2) tick();
        chk("wait_busy", 32'(busy), 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stat_start", 32'(tx_start), 1);
        chk("stat_byte", 32'(tx_data), 32'(v[i].stat));
        repeat (2) tick();
        chk("stat_wait_busy", 32'(busy), 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle_busy", 32'(busy), 0);
        chk("a_hold", 32'(alu_a), 32'(v[i].a));
        chk("b_hold", 32'(alu_b), 32'(v[i].b));
        chk("no_frame_err", 32'(fe_cnt - fe0), 0);
        tick();
        chk("tx_start_count", 32'(ts_cnt - ts0), 2);
    endtask

    initial begin
        int fe0, ts0;
        v[0] = '{8'h05, 8'h03, 8'h02, 8'h08, 8'h00};
        v[1] = '{8'h7F, 8'h7F, 8'h06, 8'h00, 8'h01};
        v[2] = '{8'h0A, 8'h0B, 8'hF9, 8'hFF, 8'h02};
        v[3] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        v[4] = '{8'h04, 8'h02, 8'h00, 8'h00, 8'h00};
        v[5] = '{8'hFE, 8'h01, 8'h07, 8'h01, 8'h00};
        v[6] = '{8'h03, 8'h05, 8'h06, 8'hFE, 8'h00};

        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_sel", 32'(alu_sel), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) run_frame(i, 1, 1'b0);
        run_frame(5, 1, 1'b0);
        run_frame(6, 1, 1'b1);

        // inter-byte timeout after a lone A byte
        fe0 = fe_cnt;
        ts0 = ts_cnt;
        send(8'h11);
        for (int k = 1; k <= T + 3; k++) begin
            tick();
            if (k == T - 1) begin
                chk("to_not_yet", 32'(frame_err), 0);
                chk("to_busy_before", 32'(busy), 1);
            end
            if (k == T) begin
                chk("to_frame_err", 32'(frame_err), 1);
                chk("to_idle", 32'(busy), 0);
            end
        end
        chk("to_single_pulse", 32'(fe_cnt - fe0), 1);
        chk("to_no_tx", 32'(ts_cnt - ts0), 0);
        chk("to_partial_a", 32'(alu_a), 32'h11);
        // B arrives in the very cycle the timeout would fire: the byte wins
        run_frame(3, T - 1, 1'b0);

        // reset while waiting for the result byte to go out
        send(8'h09);
        send(8'h01);
        send(8'h02);
        repeat (2) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_alu_a", 32'(alu_a), 0);
        chk("mid_rst_alu_b", 32'(alu_b), 0);
        chk("mid_rst_alu_sel", 32'(alu_sel), 0);
        @(negedge clk) reset = 1'b0;
        tick();
        ts0 = ts_cnt;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("stale_tx_done_busy", 32'(busy), 0);
        chk("stale_tx_done_start", 32'(ts_cnt - ts0), 0);
        run_frame(4, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
